// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, computes the effective address,
// runs a single memory-controller transaction and returns a one-cycle writeback.
// Illegal funct3 values fault immediately without touching memory.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses also fault.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [11:0] req_offset,
  input  logic [31:0] req_store_data,
  input  logic [4:0]  req_rd,
  output logic        mc_start,
  output logic [31:0] mc_address,
  output logic [2:0]  mc_mode,
  output logic        mc_write_enable,
  output logic [31:0] mc_write_data,
  input  logic        mc_done,
  input  logic [31:0] mc_read_data,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_fault,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  logic        store_q;
  logic [4:0]  rd_q;
  logic [31:0] eff_addr_c;
  logic        legal_c;
  logic        misalign_c;
  logic        req_fault_c;

  // Effective address with sign-extended 12-bit offset, 32-bit wrap-around
  assign eff_addr_c = req_base + {{20{req_offset[11]}}, req_offset};

  // Decide whether the incoming request must fault instead of reaching memory
  always_comb begin
    legal_c    = 1'b0;
    misalign_c = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal_c = 1'b1;
      3'b100, 3'b101:         legal_c = ~req_store;
      default:                legal_c = 1'b0;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01)
      misalign_c = eff_addr_c[0];
    else if (req_funct3[1:0] == 2'b10)
      misalign_c = (eff_addr_c[1:0] != 2'b00);
`endif
    req_fault_c = ~legal_c | misalign_c;
  end

  // Request sequencing with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      req_ready       <= 1'b1;
      mc_start        <= 1'b0;
      mc_address      <= 32'd0;
      mc_mode         <= 3'd0;
      mc_write_enable <= 1'b0;
      mc_write_data   <= 32'd0;
      wb_valid        <= 1'b0;
      wb_we           <= 1'b0;
      wb_rd           <= 5'd0;
      wb_data         <= 32'd0;
      wb_fault        <= 1'b0;
      busy            <= 1'b0;
      store_q         <= 1'b0;
      rd_q            <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            store_q   <= req_store;
            rd_q      <= req_rd;
            if (req_fault_c) begin
              // Faulting requests bypass memory entirely
              state    <= RESP;
              wb_valid <= 1'b1;
              wb_fault <= 1'b1;
              wb_we    <= 1'b0;
              wb_data  <= 32'd0;
              wb_rd    <= req_rd;
            end else begin
              state           <= ISSUE;
              mc_start        <= 1'b1;
              mc_address      <= eff_addr_c;
              mc_mode         <= req_funct3;
              mc_write_enable <= req_store;
              mc_write_data   <= req_store_data;
            end
          end
        end
        ISSUE: begin
          mc_start <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (mc_done) begin
            mc_write_enable <= 1'b0;
            wb_valid        <= 1'b1;
            wb_we           <= ~store_q & (rd_q != 5'd0);
            wb_data         <= store_q ? 32'd0 : mc_read_data;
            wb_rd           <= rd_q;
            wb_fault        <= 1'b0;
            state           <= RESP;
          end
        end
        RESP: begin
          wb_valid  <= 1'b0;
          wb_we     <= 1'b0;
          wb_fault  <= 1'b0;
          wb_data   <= 32'd0;
          wb_rd     <= 5'd0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized requests checked
// against a behavioural model of address, fault and writeback rules.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [11:0] req_offset;
  logic [31:0] req_store_data;
  logic [4:0]  req_rd;
  logic        mc_start;
  logic [31:0] mc_address;
  logic [2:0]  mc_mode;
  logic        mc_write_enable;
  logic [31:0] mc_write_data;
  logic        mc_done;
  logic [31:0] mc_read_data;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_fault;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_issue  = 0;
  int start_cnt = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_store_data(req_store_data), .req_rd(req_rd),
    .mc_start(mc_start), .mc_address(mc_address), .mc_mode(mc_mode),
    .mc_write_enable(mc_write_enable), .mc_write_data(mc_write_data),
    .mc_done(mc_done), .mc_read_data(mc_read_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_fault(wb_fault), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which the controller sees a start pulse
  always @(posedge clk) if (mc_start) start_cnt <= start_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference: base plus signed 12-bit offset, modulo 2^32
  function automatic logic [31:0] model_addr(input logic [31:0] base, input logic [11:0] off);
    int soff;
    soff = (int'(off) >= 2048) ? int'(off) - 4096 : int'(off);
    return base + 32'(soff);
  endfunction

  // Reference: legal width codes per direction, optional alignment trap
  function automatic logic model_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int legal_ld[5] = '{0, 1, 2, 4, 5};
    int legal_st[3] = '{0, 1, 2};
    logic ok;
    int size;
    ok = 1'b0;
    if (st) begin
      foreach (legal_st[i]) if (int'(f3) == legal_st[i]) ok = 1'b1;
    end else begin
      foreach (legal_ld[i]) if (int'(f3) == legal_ld[i]) ok = 1'b1;
    end
    if (!ok) return 1'b1;
    size = 1 << (int'(f3) % 4);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a % 32'(size)) != 32'd0) return 1'b1;
`else
    if (size < 0 && a == 32'd0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // One complete request; leaves req_valid high so the next call is back-to-back
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                        input logic [11:0] off, input logic [31:0] sdata, input logic [4:0] rd,
                        input int dly, input logic [31:0] rdata);
    logic [31:0] ea;
    logic flt;
    ea  = model_addr(base, off);
    flt = model_fault(st, f3, ea);
    chk("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_base = base;
    req_offset = off; req_store_data = sdata; req_rd = rd;
    @(posedge clk); #1;
    if (flt) begin
      chk("flt_start", 32'(mc_start), 32'd0);
      chk("flt_wen", 32'(mc_write_enable), 32'd0);
      chk("flt_valid", 32'(wb_valid), 32'd1);
      chk("flt_fault", 32'(wb_fault), 32'd1);
      chk("flt_we", 32'(wb_we), 32'd0);
      chk("flt_data", wb_data, 32'd0);
      chk("flt_rd", 32'(wb_rd), 32'(rd));
      chk("flt_busy", 32'(busy), 32'd1);
    end else begin
      n_issue++;
      chk("iss_start", 32'(mc_start), 32'd1);
      chk("iss_addr", mc_address, ea);
      chk("iss_mode", 32'(mc_mode), 32'(f3));
      chk("iss_wen", 32'(mc_write_enable), 32'(st));
      if (st) chk("iss_wdata", mc_write_data, sdata);
      chk("iss_ready", 32'(req_ready), 32'd0);
      chk("iss_busy", 32'(busy), 32'd1);
      chk("iss_valid", 32'(wb_valid), 32'd0);
      mc_done = 1'($urandom % 2);
      mc_read_data = $urandom;
      for (int k = 0; k <= dly; k++) begin
        @(posedge clk); #1;
        mc_done = 1'b0;
        chk("wait_start", 32'(mc_start), 32'd0);
        chk("wait_addr", mc_address, ea);
        chk("wait_mode", 32'(mc_mode), 32'(f3));
        chk("wait_wen", 32'(mc_write_enable), 32'(st));
        chk("wait_valid", 32'(wb_valid), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        if (k == dly) begin
          mc_done = 1'b1;
          mc_read_data = rdata;
        end else begin
          mc_read_data = $urandom;
        end
      end
      @(posedge clk); #1;
      mc_done = 1'b0;
      mc_read_data = $urandom;
      chk("resp_valid", 32'(wb_valid), 32'd1);
      chk("resp_fault", 32'(wb_fault), 32'd0);
      chk("resp_we", 32'(wb_we), 32'((!st) && (rd != 5'd0)));
      chk("resp_data", wb_data, st ? 32'd0 : rdata);
      chk("resp_rd", 32'(wb_rd), 32'(rd));
      chk("resp_wen", 32'(mc_write_enable), 32'd0);
      chk("resp_start", 32'(mc_start), 32'd0);
      chk("resp_busy", 32'(busy), 32'd1);
      chk("resp_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk("idle_valid", 32'(wb_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_base = 32'd0; req_offset = 12'd0; req_store_data = 32'd0; req_rd = 5'd0;
    mc_done = 1'b0; mc_read_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_start", 32'(mc_start), 32'd0);
    chk("rst_wen", 32'(mc_write_enable), 32'd0);
    chk("rst_addr", mc_address, 32'd0);
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_fault", 32'(wb_fault), 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word load, byte store with negative offset, rd=0 load, illegal funct3
    do_req(1'b0, 3'b010, 32'h100, 12'h004, 32'h0, 5'd5, 1, 32'h12345678);
    do_req(1'b1, 3'b000, 32'h200, 12'hFFF, 32'hAABBCCDD, 5'd7, 2, 32'hDEADBEEF);
    do_req(1'b0, 3'b100, 32'h300, 12'h010, 32'h0, 5'd0, 0, 32'h000000FF);
    do_req(1'b0, 3'b011, 32'h300, 12'h010, 32'h0, 5'd9, 0, 32'h0);
    do_req(1'b1, 3'b100, 32'h400, 12'h000, 32'h1, 5'd3, 0, 32'h0);
    // Misaligned word load: faults only when the alignment trap is built in
    do_req(1'b0, 3'b010, 32'h100, 12'h002, 32'h0, 5'd4, 1, 32'hCAFEF00D);
    // Address wrap-around past 2^32
    do_req(1'b0, 3'b000, 32'hFFFFFFFF, 12'h002, 32'h0, 5'd1, 0, 32'h00000080);

    // Randomized back-to-back traffic
    for (int i = 0; i < 40; i++) begin
      logic st;
      logic [2:0] f3;
      logic [31:0] base;
      st   = 1'($urandom % 2);
      f3   = 3'($urandom_range(0, 7));
      base = $urandom;
      if ($urandom % 2 == 0) base = base & 32'hFFFFF000;
      do_req(st, f3, base, 12'($urandom), $urandom, 5'($urandom), $urandom_range(0, 3), $urandom);
    end

    // Reset in the second WAIT cycle aborts the store
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_base = 32'h500;
    req_offset = 12'h008; req_store_data = 32'h55AA55AA; req_rd = 5'd2;
    @(posedge clk); #1;
    n_issue++;
    req_valid = 1'b0;
    chk("abort_iss_start", 32'(mc_start), 32'd1);
    @(posedge clk); #1;
    chk("abort_w1_wen", 32'(mc_write_enable), 32'd1);
    @(posedge clk); #1;
    chk("abort_w2_wen", 32'(mc_write_enable), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_valid", 32'(wb_valid), 32'd0);
    chk("abort_wen", 32'(mc_write_enable), 32'd0);
    chk("abort_start", 32'(mc_start), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    mc_done = 1'b1;
    mc_read_data = 32'h0BADF00D;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stray_valid", 32'(wb_valid), 32'd0);
      chk("stray_busy", 32'(busy), 32'd0);
      chk("stray_ready", 32'(req_ready), 32'd1);
    end
    mc_done = 1'b0;

    // Normal operation resumes after the abort
    do_req(1'b0, 3'b001, 32'h600, 12'h002, 32'h0, 5'd8, 1, 32'h0000BEEF);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("start_count", 32'(start_cnt), 32'(n_issue));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have ports: req_valid in 1 request present; req_ready out 1 unit can accept; req_store in 1 1=store, 0=load; req_funct3 in 3 load/store FUNC3; req_base in 32 rs1 value; req_offset in 12 signed immediate; req_store_data in 32 rs2 value; req_rd in 5 load destination register.
REQ-004 SHALL have ports: mc_start out 1; mc_address out 32; mc_mode out 3; mc_write_enable out 1; mc_write_data out 32; mc_done in 1; mc_read_data in 32. These connect to the downstream memory controller.
REQ-005 SHALL have ports: wb_valid out 1 one-cycle completion; wb_we out 1 register write enable; wb_rd out 5; wb_data out 32; wb_fault out 1 request rejected; busy out 1 operation in flight.

Function
REQ-006 SHALL implement states IDLE, ISSUE, WAIT, RESP. IDLE->ISSUE on accept; ISSUE->WAIT unconditionally; WAIT->RESP on mc_done=1; RESP->IDLE unconditionally.
REQ-007 SHALL assert req_ready only in IDLE; accept when req_valid=1 and req_ready=1 at a rising edge.
REQ-008 On accept, SHALL register store flag, funct3, rd, store data and effective address = req_base + sign_extend(req_offset), with 32-bit wrap-around and no carry out.
REQ-009 SHALL assert mc_start for exactly one cycle, the ISSUE cycle, and never in any other state.
REQ-010 SHALL hold mc_address, mc_mode (=registered funct3), mc_write_data and mc_write_enable stable from ISSUE through the WAIT cycle in which mc_done=1.
REQ-011 SHALL drive mc_write_enable=1 only in ISSUE/WAIT of an accepted store; it SHALL be 0 in IDLE, RESP and for all loads, because the controller writes memory whenever enable is high.
REQ-012 SHALL ignore mc_done outside WAIT.
REQ-013 In WAIT with mc_done=1, SHALL capture mc_read_data into wb_data for loads; for stores wb_data SHALL be 0.
REQ-014 In RESP, SHALL drive wb_valid=1 for one cycle with wb_rd=registered rd, and wb_we=1 only for a non-faulting load with rd!=0.
REQ-015 Legal funct3 SHALL be: loads 000, 001, 010, 100, 101; stores 000, 001, 010. Any other value SHALL skip ISSUE/WAIT (IDLE->RESP), issue no mc_start, and give wb_fault=1, wb_we=0, wb_data=0.
REQ-016 busy SHALL be 1 in ISSUE, WAIT and RESP, and 0 in IDLE.
REQ-017 Minimum latency: accept edge N; mc_start high in cycle N+1; wb_valid high the cycle after the edge that samples mc_done=1.
REQ-018 The WAIT state SHALL have no timeout; the unit stalls until mc_done arrives.

Reset
REQ-019 With rst=1 at a rising edge, SHALL enter IDLE and clear all outputs to 0 except req_ready, which is 1 after reset.
REQ-020 Reset during ISSUE/WAIT/RESP SHALL abort the operation with no wb_valid, and SHALL deassert mc_start and mc_write_enable on the next cycle.
REQ-021 Resetting the memory controller on abort is handled by the system reset, not by this unit.

Configuration
REQ-022 Macro LSU_MISALIGN_TRAP_EN: when defined, a halfword access (funct3[1:0]=01) with addr[0]!=0, or a word access (10) with addr[1:0]!=0, SHALL be handled like REQ-015 (IDLE->RESP, wb_fault=1, no memory access).
REQ-023 Without LSU_MISALIGN_TRAP_EN, misaligned accesses SHALL be issued normally, because the controller is byte-serial; wb_fault SHALL then be asserted only for illegal funct3.

Verification
REQ-024 Load word, base=0x100, offset=0x004, funct3=010, rd=5; controller returns 0x12345678 -> mc_start one cycle with address 0x104 and mode 010; wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x12345678.
REQ-025 Store byte, base=0x200, offset=-1 (0xFFF), data=0xAABBCCDD -> mc_address=0x1FF, mc_write_enable=1 from ISSUE to mc_done, then 0; wb_valid with wb_we=0.
REQ-026 Load with rd=0 -> full memory cycle, wb_valid=1, wb_we=0. Then funct3=011 -> no mc_start, wb_fault=1 within 2 cycles of accept.
REQ-027 Word load at 0x102 -> with macro: wb_fault=1 and mc_start never asserted; without macro: mc_address=0x102 issued and wb_fault=0.
REQ-028 rst=1 in the second WAIT cycle, with mc_done arriving later -> no wb_valid, mc_write_enable=0, req_ready=1 on the next cycle; stray mc_done in IDLE is ignored.
REQ-029 Back-to-back requests with req_valid held high -> second accept occurs in the cycle after RESP; exactly one mc_start per request.
